// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
// Per-register latency scoreboard for an in-order pipeline: detects RAW/WAW/structural
// hazards at ID, stalls/bubbles accordingly, and squashes IF/ID after taken branches.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 8,
  parameter int BR_SLOTS   = 1,
  parameter int CW         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    rs_ID,
  input  logic [REG_AW-1:0]    rt_ID,
  input  logic                 rs_used,
  input  logic                 rt_used,
  input  logic [REG_AW-1:0]    rd_ID,
  input  logic                 RegWrite_ID,
  input  logic [1:0]           cls_ID,
  input  logic                 Branch_taken,
  output logic                 stall,
  output logic                 IDEX_flush,
  output logic                 IFID_flush,
  output logic [1:0]           hazard_cause,
  output logic [2**REG_AW-1:0] pending_mask
);

  localparam int NREG = 2**REG_AW;

  localparam logic [1:0]    CLS_LOAD   = 2'd1;
  localparam logic [1:0]    CLS_MULDIV = 2'd2;
  localparam logic [CW-1:0] LOAD_L     = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MULDIV_L   = CW'(MULDIV_LAT);
  localparam logic [CW-1:0] FLUSH_L    = CW'(BR_SLOTS - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_RAW    = 2'd1;
  localparam logic [1:0] CAUSE_WAW    = 2'd2;
  localparam logic [1:0] CAUSE_STRUCT = 2'd3;

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] busy_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] lat;

  logic raw_hz;
  logic waw_hz;
  logic struct_hz;
  logic hazard;
  logic issue;
  logic wr_en;
  logic br_act;

  always_comb begin
    case (cls_ID)
      CLS_LOAD:   lat = LOAD_L;
      CLS_MULDIV: lat = MULDIV_L;
      default:    lat = '0;
    endcase
  end

  // Register 0 is excluded explicitly even though its counter is held at zero.
  assign raw_hz = id_valid &&
                  ((rs_used && (rs_ID != '0) && (cnt[rs_ID] != '0)) ||
                   (rt_used && (rt_ID != '0) && (cnt[rt_ID] != '0)));

  assign waw_hz    = id_valid && RegWrite_ID && (rd_ID != '0) && (lat < cnt[rd_ID]);
  assign struct_hz = id_valid && (cls_ID == CLS_MULDIV) && (busy_cnt != '0);

  assign hazard = raw_hz || waw_hz || struct_hz;
  assign issue  = id_valid && !hazard;
  assign wr_en  = issue && RegWrite_ID && (rd_ID != '0);
  assign br_act = issue && Branch_taken;

  assign stall      = hazard;
  assign IDEX_flush = hazard;
  // Branch_taken is a raw input, so gate it explicitly while reset is held.
  assign IFID_flush = !reset && (br_act || (flush_cnt != '0));

  always_comb begin
    if (raw_hz)         hazard_cause = CAUSE_RAW;
    else if (waw_hz)    hazard_cause = CAUSE_WAW;
    else if (struct_hz) hazard_cause = CAUSE_STRUCT;
    else                hazard_cause = CAUSE_NONE;
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      pending_mask[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      busy_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (wr_en && (rd_ID == REG_AW'(i)))
          cnt[i] <= lat;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - ONE;
      end

      if (issue && (cls_ID == CLS_MULDIV))
        busy_cnt <= MULDIV_L;
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - ONE;

      if (br_act)
        flush_cnt <= FLUSH_L;
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - ONE;
    end
  end

endmodule
